// File: rtl/msg_schedule_if.sv
// Chunk-word handshake into the SHA-256 message scheduler.
// The producer drives the word side; the scheduler answers with ready.
interface msg_schedule_if;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [31:0] msg_word_i;
    logic        msg_first_i;

    modport master (
        output msg_valid_i,
        output msg_word_i,
        output msg_first_i,
        input  msg_ready_o
    );

    modport slave (
        input  msg_valid_i,
        input  msg_word_i,
        input  msg_first_i,
        output msg_ready_o
    );
endinterface

// File: rtl/msg_schedule.sv
// SHA-256 message scheduler: loads a 16-word chunk, then streams W_t/K_t
// for 64 rounds, each pair held for one compression-loop iteration period.
module msg_schedule #(
    parameter int ROUNDS        = 64,
    parameter int CYC_PER_ROUND = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    msg_schedule_if.slave msg,
    output logic [31:0]   w_o,
    output logic [31:0]   k_o,
    output logic          clr_o,
    output logic          update_o,
    output logic          busy_o
);

    localparam int RND_W = $clog2(ROUNDS);
    localparam int PH_W  = (CYC_PER_ROUND > 1) ? $clog2(CYC_PER_ROUND) : 1;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        UPDATE
    } state_t;

    state_t             state;
    logic [31:0]        win [16];
    logic [3:0]         wcnt;
    logic [RND_W-1:0]   rnd;
    logic [RND_W-1:0]   rnd_nxt;
    logic [PH_W-1:0]    ph;
    logic               accept;
    logic               last_ph;
    logic               last_rnd;
    logic [31:0]        part_hi;
    logic [31:0]        part_lo;
    logic [31:0]        w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign accept   = msg.msg_valid_i & msg.msg_ready_o;
    assign last_ph  = (ph == PH_W'(CYC_PER_ROUND - 1));
    assign last_rnd = (rnd == RND_W'(ROUNDS - 1));
    assign rnd_nxt  = rnd + 1'b1;
    assign w_new    = part_hi + part_lo;

    // Two-stage expansion adder: partial sums track the window every cycle,
    // the window only moves at the round boundary, so they are settled by then.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            part_hi <= '0;
            part_lo <= '0;
        end else begin
            part_hi <= sig1(win[14]) + win[9];
            part_lo <= sig0(win[1]) + win[0];
        end
    end

    // Control FSM, window storage/shift and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            wcnt            <= '0;
            rnd             <= '0;
            ph              <= '0;
            msg.msg_ready_o <= 1'b1;
            w_o             <= '0;
            k_o             <= '0;
            clr_o           <= 1'b0;
            update_o        <= 1'b0;
            busy_o          <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            clr_o    <= 1'b0;
            update_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        win[0] <= msg.msg_word_i;
                        wcnt   <= 4'd1;
                        clr_o  <= msg.msg_first_i;
                        busy_o <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        win[wcnt] <= msg.msg_word_i;
                        wcnt      <= wcnt + 4'd1;
                        if (wcnt == 4'd15) begin
                            state           <= RUN;
                            rnd             <= '0;
                            ph              <= '0;
                            msg.msg_ready_o <= 1'b0;
                            w_o             <= win[0];
                            k_o             <= K_ROM[0];
                        end
                    end
                end
                RUN: begin
                    if (last_ph) begin
                        ph <= '0;
                        if (last_rnd) begin
                            update_o <= 1'b1;
                            state    <= UPDATE;
                        end else begin
                            rnd <= rnd_nxt;
                            w_o <= win[1];
                            k_o <= K_ROM[rnd_nxt];
                            for (int i = 0; i < 15; i++) begin
                                win[i] <= win[i+1];
                            end
                            win[15] <= w_new;
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                UPDATE: begin
                    state           <= IDLE;
                    msg.msg_ready_o <= 1'b1;
                    busy_o          <= 1'b0;
                    wcnt            <= '0;
                    rnd             <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
